// File: rtl/defunnel_gather_param.sv
// ---------------------------------------------------------------------------
// defunnel_gather_param
//
// Lane-gathering defunnel. Each handshake packs k = 1, 2, 4 ... T_LANES narrow
// input lanes into consecutive slots of a SLOTS-wide output word. A full word
// is presented on a single req/ack initiator port. When the consumer acks a
// full word, a beat can be accepted in the same cycle to refill slots 0..k-1,
// so a steady stream of producers sees no bubble between words.
//
// The lane count k comes from the mode input. The mode is latched only at the
// start of a word (nothing valid and pointer at slot 0), so the whole word is
// gathered with one lane count even if mode changes part way through.
//
// Optional feature, enabled by defining DEFUNNEL_FLUSH_EN:
//   adds a 'flush' input. A flush with a partial word pending presents that
//   partial word (i_mask shows which slots are valid), blocks further accepts
//   until it is acked, and then restarts gathering at slot 0.
// Without the macro there is no flush port and i_req only ever rises on a
// completely full word.
// ---------------------------------------------------------------------------
module defunnel_gather_param #(
    parameter int T_LANES = 4,
    parameter int SLOTS   = 8,
    parameter int DW      = 32,
    parameter int MW      = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [T_LANES-1:0]      t_req,
    output logic [T_LANES-1:0]      t_ack,
    input  logic [T_LANES*DW-1:0]   t_data,
    input  logic [MW-1:0]           mode,
    output logic                    i_req,
    input  logic                    i_ack,
    output logic [SLOTS*DW-1:0]     i_data,
    output logic [SLOTS-1:0]        i_mask
`ifdef DEFUNNEL_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    // Pointer width; a single-slot build still gets a 1-bit pointer that is
    // masked down to zero so no zero-width vectors appear.
    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int KW = PW + 1;
    localparam logic [PW-1:0] PTR_MASK = PW'(SLOTS - 1);

    // Word state
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [SLOTS-1:0]   valid_q;
    logic [SLOTS-1:0]   valid_d;
    logic [DW-1:0]      slot_q [SLOTS];
    logic [DW-1:0]      slot_d [SLOTS];
    logic [MW-1:0]      mode_q;
    logic [MW-1:0]      mode_d;

    // Decoded controls
    logic [KW-1:0]      kLanes;
    logic [T_LANES-1:0] laneMask;
    logic [KW-1:0]      ptrSum;
    logic [SLOTS-1:0]   slotSet;
    logic               modeActive;
    logic               full;
    logic               space;
    logic               drain;
    logic               accept;
    logic               wordStart;
    logic               flushPend;
    logic               flushDrain;

    // Decode lanes-per-beat from the latched mode: the lowest set bit wins,
    // so the loop runs high-to-low and the last hit is the one that sticks.
    always_comb begin
        kLanes = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (mode_q[i]) begin
                kLanes = KW'(1 << i);
            end
        end
    end

    // Lanes 0..k-1 take part in a beat; higher lanes are acked but ignored.
    always_comb begin
        laneMask = '0;
        for (int j = 0; j < T_LANES; j++) begin
            laneMask[j] = (KW'(j) < kLanes);
        end
    end

    assign modeActive = |mode_q;
    assign full       = &valid_q;
    assign i_req      = full | flushPend;
    assign drain      = i_req & i_ack;
    // A full word frees its slots in the same cycle it is acked.
    assign space      = ~full | i_ack;
    assign accept     = modeActive & ((t_req & laneMask) == laneMask) & space & ~flushPend;
    assign wordStart  = (valid_q == '0) && (ptr_q == '0);
    assign flushDrain = drain & flushPend;

    // Steer lane j of an accepted beat into slot ptr+j and flag the slot as
    // newly written so it survives a same-cycle drain.
    always_comb begin
        slotSet = '0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_d[s] = slot_q[s];
            for (int j = 0; j < T_LANES; j++) begin
                if (accept && laneMask[j] &&
                    (((ptr_q + PW'(j)) & PTR_MASK) == PW'(s))) begin
                    slot_d[s]  = t_data[j*DW +: DW];
                    slotSet[s] = 1'b1;
                end
            end
        end
    end

    // Next pointer, valid mask and latched mode. Set wins over the drain
    // clear so the refill beat lands in the fresh word.
    always_comb begin
        ptrSum = {1'b0, ptr_q} + kLanes;
        ptr_d  = ptr_q;
        if (flushDrain) begin
            ptr_d = '0;
        end
        if (accept) begin
            ptr_d = ptrSum[PW-1:0] & PTR_MASK;
        end
        valid_d = (drain ? '0 : valid_q) | slotSet;
        mode_d  = wordStart ? mode : mode_q;
    end

`ifdef DEFUNNEL_FLUSH_EN
    logic flushPend_q;
    logic flushPend_d;

    // Flush of a partial word arms the pending flag; the ack that consumes
    // the partial word clears it. A full word already drains normally.
    always_comb begin
        flushPend_d = flushPend_q;
        if (drain) begin
            flushPend_d = 1'b0;
        end else if (flush && (|valid_q) && !full) begin
            flushPend_d = 1'b1;
        end
    end

    // Pending-flush register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flushPend_q <= 1'b0;
        end else begin
            flushPend_q <= flushPend_d;
        end
    end

    assign flushPend = flushPend_q;
`else
    assign flushPend = 1'b0;
`endif

    // Word state registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            valid_q <= '0;
            mode_q  <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            for (int s = 0; s < SLOTS; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

    // Flatten the slot registers onto the output word.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            i_data[s*DW +: DW] = slot_q[s];
        end
    end

    assign i_mask = valid_q;
    assign t_ack  = {T_LANES{accept}};

endmodule

// File: tb/tb_defunnel_gather_param.sv
// ---------------------------------------------------------------------------
// tb_defunnel_gather_param
//
// Self-checking bench for defunnel_gather_param with default parameters.
// A behavioural word model (slot array, valid array, pointer, latched mode)
// predicts every output each cycle. A constant vector table and hand-written
// sequences pin down specific behaviours; a random phase exercises the rest.
// Builds with or without DEFUNNEL_FLUSH_EN.
// ---------------------------------------------------------------------------
module tb_defunnel_gather_param;

    localparam int T  = 4;
    localparam int S  = 8;
    localparam int DW = 32;
    localparam int MW = 3;
`ifdef DEFUNNEL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [T-1:0]    t_req;
    logic [T-1:0]    t_ack;
    logic [T*DW-1:0] t_data;
    logic [MW-1:0]   mode;
    logic            i_req;
    logic            i_ack;
    logic [S*DW-1:0] i_data;
    logic [S-1:0]    i_mask;
    logic            flush;

    // Free-running clock
    always #5 clk = ~clk;

    defunnel_gather_param #(
        .T_LANES(T), .SLOTS(S), .DW(DW), .MW(MW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .t_req   (t_req),
        .t_ack   (t_ack),
        .t_data  (t_data),
        .mode    (mode),
        .i_req   (i_req),
        .i_ack   (i_ack),
        .i_data  (i_data),
        .i_mask  (i_mask)
`ifdef DEFUNNEL_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Behavioural model of the word being gathered
    logic [DW-1:0] mSlot [S];
    logic [S-1:0]  mValid;
    int            mPtr;
    logic [MW-1:0] mModeQ;
    bit            mPend;

    // Model outputs for the current cycle, shared by check and advance
    bit expAcc;
    bit expReq;
    bit expFull;
    int expK;

    typedef struct {
        logic [T-1:0]  req;
        logic [MW-1:0] md;
        logic          ack;
        logic [T-1:0]  expAck;
        logic          expReq;
        logic [S-1:0]  expMask;
    } vec_t;

    vec_t vecs [15];

    // Watchdog so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [T*DW-1:0] lanes4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic modelReset();
        mValid = '0;
        mPtr   = 0;
        mModeQ = '0;
        mPend  = 1'b0;
        for (int s = 0; s < S; s++) mSlot[s] = '0;
    endtask

    // Lowest set bit of the latched mode gives 2^i lanes per beat
    function automatic int modelK();
        for (int i = 0; i < MW; i++) begin
            if (mModeQ[i]) return 1 << i;
        end
        return 0;
    endfunction

    task automatic applyStimulus(input logic [T-1:0] req, input logic [T*DW-1:0] data,
                                 input logic [MW-1:0] md, input logic ack, input logic fl);
        t_req  = req;
        t_data = data;
        mode   = md;
        i_ack  = ack;
        flush  = fl;
        @(negedge clk);
    endtask

    task automatic checkOutput();
        bit lanesOk;
        expK    = modelK();
        expFull = (mValid == '1);
        expReq  = expFull | mPend;
        lanesOk = 1'b1;
        for (int j = 0; j < expK; j++) begin
            if (!t_req[j]) lanesOk = 1'b0;
        end
        expAcc = (expK != 0) && lanesOk && (!expFull || i_ack) && !mPend;
        compare("t_ack", t_ack, {T{expAcc}});
        compare("i_req", i_req, expReq);
        compare("i_mask", i_mask, mValid);
        for (int s = 0; s < S; s++) begin
            if (mValid[s]) compare($sformatf("slot%0d", s), i_data[s*DW +: DW], mSlot[s]);
        end
    endtask

    task automatic modelAdvance();
        bit startOfWord;
        bit drain;
        startOfWord = (mValid == '0) && (mPtr == 0);
        drain       = expReq && i_ack;
        if (drain) begin
            mValid = '0;
            if (mPend) begin
                mPtr  = 0;
                mPend = 1'b0;
            end
        end else if (FLUSH_EN && flush && (mValid != '0) && !expFull && !mPend) begin
            mPend = 1'b1;
        end
        if (expAcc) begin
            for (int j = 0; j < expK; j++) begin
                mSlot[(mPtr + j) % S]  = t_data[j*DW +: DW];
                mValid[(mPtr + j) % S] = 1'b1;
            end
            mPtr = (mPtr + expK) % S;
        end
        if (startOfWord) mModeQ = mode;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [T-1:0] req, input logic [T*DW-1:0] data,
                         input logic [MW-1:0] md, input logic ack, input logic fl);
        applyStimulus(req, data, md, ack, fl);
        checkOutput();
        modelAdvance();
        nextCycle();
    endtask

    // Asynchronous reset with all lanes requesting; outputs must stay quiet
    task automatic resetDut();
        reset_n = 1'b0;
        t_req   = '1;
        mode    = 3'b100;
        i_ack   = 1'b0;
        flush   = 1'b0;
        t_data  = '0;
        #2;
        compare("reset_t_ack", t_ack, 0);
        compare("reset_i_req", i_req, 0);
        compare("reset_i_mask", i_mask, 0);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [S*DW-1:0] expWord;
        logic [DW-1:0]   ltr [12];
        logic [T-1:0]    rq;
        logic [MW-1:0]   md;

        reset_n = 1'b1;
        t_req   = '0;
        t_data  = '0;
        mode    = '0;
        i_ack   = 1'b0;
        flush   = 1'b0;
        for (int i = 0; i < 12; i++) ltr[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        #1;

        // Table: reset with mode 0, k=2 partial requests, mode change mid-word
        vecs[0]  = '{4'b1111, 3'b000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{4'b1111, 3'b010, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[2]  = '{4'b0001, 3'b010, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[3]  = '{4'b0011, 3'b010, 1'b0, 4'b1111, 1'b0, 8'h00};
        vecs[4]  = '{4'b0000, 3'b010, 1'b0, 4'b0000, 1'b0, 8'h03};
        vecs[5]  = '{4'b1111, 3'b010, 1'b0, 4'b1111, 1'b0, 8'h03};
        vecs[6]  = '{4'b0011, 3'b001, 1'b0, 4'b1111, 1'b0, 8'h0F};
        vecs[7]  = '{4'b0011, 3'b001, 1'b0, 4'b1111, 1'b0, 8'h3F};
        vecs[8]  = '{4'b1111, 3'b001, 1'b0, 4'b0000, 1'b1, 8'hFF};
        vecs[9]  = '{4'b0000, 3'b001, 1'b1, 4'b0000, 1'b1, 8'hFF};
        vecs[10] = '{4'b0000, 3'b001, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[11] = '{4'b0001, 3'b001, 1'b0, 4'b1111, 1'b0, 8'h00};
        vecs[12] = '{4'b0000, 3'b001, 1'b1, 4'b0000, 1'b0, 8'h01};
        vecs[13] = '{4'b0000, 3'b001, 1'b0, 4'b0000, 1'b0, 8'h01};
        vecs[14] = '{4'b0010, 3'b001, 1'b0, 4'b0000, 1'b0, 8'h01};

        resetDut();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].req,
                          lanes4(32'hA000_0000 + 32'(i << 8), 32'hA000_0001 + 32'(i << 8),
                                 32'hA000_0002 + 32'(i << 8), 32'hA000_0003 + 32'(i << 8)),
                          vecs[i].md, vecs[i].ack, 1'b0);
            checkOutput();
            compare($sformatf("vec%0d_t_ack", i), t_ack, vecs[i].expAck);
            compare($sformatf("vec%0d_i_req", i), i_req, vecs[i].expReq);
            compare($sformatf("vec%0d_i_mask", i), i_mask, vecs[i].expMask);
            modelAdvance();
            nextCycle();
        end

        // k=1: eight single-lane beats, i_req the cycle after the last, no bubble
        resetDut();
        cycle(4'b0000, '0, 3'b001, 1'b1, 1'b0);
        expWord = '0;
        for (int b = 0; b < 8; b++) begin
            expWord[b*DW +: DW] = 32'hD0D0_0000 + 32'(b);
            applyStimulus(4'b0001, lanes4(32'hD0D0_0000 + 32'(b), 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003),
                          3'b001, 1'b1, 1'b0);
            checkOutput();
            compare("k1_beat_ack", t_ack, 4'b1111);
            compare("k1_beat_noreq", i_req, 1'b0);
            modelAdvance();
            nextCycle();
        end
        applyStimulus(4'b0001, lanes4(32'hD0D0_0008, 32'h0, 32'h0, 32'h0), 3'b001, 1'b1, 1'b0);
        checkOutput();
        compare("k1_word_req", i_req, 1'b1);
        compare("k1_word_data", i_data, expWord);
        compare("k1_refill_ack", t_ack, 4'b1111);
        modelAdvance();
        nextCycle();
        applyStimulus(4'b0000, '0, 3'b001, 1'b0, 1'b0);
        checkOutput();
        compare("k1_refill_mask", i_mask, 8'h01);
        compare("k1_refill_slot0", i_data[DW-1:0], 32'hD0D0_0008);
        modelAdvance();
        nextCycle();

        // k=4: two beats fill, word held without ack, refill on the ack cycle
        resetDut();
        cycle(4'b0000, '0, 3'b100, 1'b0, 1'b0);
        cycle(4'b1111, lanes4(ltr[0], ltr[1], ltr[2], ltr[3]), 3'b100, 1'b0, 1'b0);
        cycle(4'b1111, lanes4(ltr[4], ltr[5], ltr[6], ltr[7]), 3'b100, 1'b0, 1'b0);
        for (int h = 0; h < 2; h++) begin
            applyStimulus(4'b1111, lanes4(ltr[8], ltr[9], ltr[10], ltr[11]), 3'b100, 1'b0, 1'b0);
            checkOutput();
            compare("k4_hold_req", i_req, 1'b1);
            compare("k4_hold_ack", t_ack, 4'b0000);
            compare("k4_hold_data", i_data, {ltr[7], ltr[6], ltr[5], ltr[4], ltr[3], ltr[2], ltr[1], ltr[0]});
            modelAdvance();
            nextCycle();
        end
        applyStimulus(4'b1111, lanes4(ltr[8], ltr[9], ltr[10], ltr[11]), 3'b100, 1'b1, 1'b0);
        checkOutput();
        compare("k4_drain_ack", t_ack, 4'b1111);
        modelAdvance();
        nextCycle();
        applyStimulus(4'b0000, '0, 3'b100, 1'b0, 1'b0);
        checkOutput();
        compare("k4_refill_mask", i_mask, 8'h0F);
        compare("k4_refill_req", i_req, 1'b0);
        compare("k4_refill_data", i_data[4*DW-1:0], {ltr[11], ltr[10], ltr[9], ltr[8]});
        modelAdvance();
        nextCycle();

        // Partial word followed by flush (or, without flush support, no i_req)
        resetDut();
        cycle(4'b0000, '0, 3'b010, 1'b0, 1'b0);
        cycle(4'b0011, lanes4(ltr[0], ltr[1], 32'h0, 32'h0), 3'b010, 1'b0, 1'b0);
        cycle(4'b0000, '0, 3'b010, 1'b0, 1'b1);
        applyStimulus(4'b1111, lanes4(ltr[2], ltr[3], ltr[4], ltr[5]), 3'b010, 1'b0, 1'b0);
        checkOutput();
`ifdef DEFUNNEL_FLUSH_EN
        compare("flush_req", i_req, 1'b1);
        compare("flush_mask", i_mask, 8'h03);
        compare("flush_blocks_ack", t_ack, 4'b0000);
        modelAdvance();
        nextCycle();
        cycle(4'b0000, '0, 3'b010, 1'b1, 1'b0);
        applyStimulus(4'b0011, lanes4(ltr[6], ltr[7], 32'h0, 32'h0), 3'b010, 1'b0, 1'b0);
        checkOutput();
        compare("flush_after_req", i_req, 1'b0);
        compare("flush_after_mask", i_mask, 8'h00);
        modelAdvance();
        nextCycle();
        applyStimulus(4'b0000, '0, 3'b010, 1'b0, 1'b0);
        checkOutput();
        compare("flush_restart_mask", i_mask, 8'h03);
        compare("flush_restart_slot0", i_data[DW-1:0], ltr[6]);
        modelAdvance();
        nextCycle();
`else
        compare("noflush_req", i_req, 1'b0);
        compare("noflush_ack", t_ack, 4'b1111);
        modelAdvance();
        nextCycle();
        applyStimulus(4'b0000, '0, 3'b010, 1'b0, 1'b0);
        checkOutput();
        compare("noflush_after_req", i_req, 1'b0);
        compare("noflush_after_mask", i_mask, 8'h0F);
        modelAdvance();
        nextCycle();
`endif

        // Random traffic against the model, with occasional mid-word resets
        resetDut();
        md = 3'($urandom_range(1, 7));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) md = 3'($urandom_range(0, 7));
            for (int j = 0; j < T; j++) rq[j] = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 399) == 0) begin
                resetDut();
            end else begin
                cycle(rq, {$urandom, $urandom, $urandom, $urandom}, md,
                      1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 29) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
